// File: rtl/cache_flush_walker_if.sv
// cache_flush_walker_if: flush walker handshake with the cacheway array and the cache bus FSM
interface cache_flush_walker_if #(
    parameter int NUMLINES = 128,
    parameter int NUMWAYS  = 4
);
    localparam int SETLEN = $clog2(NUMLINES);
    logic              FlushReq;
    logic              LineDirty;
    logic              WbAck;
    logic              SelFlush;
    logic [SETLEN-1:0] FlushAdr;
    logic [NUMWAYS-1:0] FlushWay;
    logic              WbReq;
    logic              ClearDirty;
    logic              FlushBusy;
    logic              FlushDone;
    modport master (
        input  FlushReq, LineDirty, WbAck,
        output SelFlush, FlushAdr, FlushWay, WbReq, ClearDirty, FlushBusy, FlushDone
    );
    modport slave (
        output FlushReq, LineDirty, WbAck,
        input  SelFlush, FlushAdr, FlushWay, WbReq, ClearDirty, FlushBusy, FlushDone
    );
endinterface

// File: rtl/cache_flush_walker.sv
// cache_flush_walker: walks every (set, way) on a flush, writing back and clearing dirty lines
module cache_flush_walker #(
    parameter int NUMLINES = 128,
    parameter int NUMWAYS  = 4
) (
    input logic clk,
    input logic reset,
    cache_flush_walker_if.master bus
);
    localparam int SETLEN = $clog2(NUMLINES);
    typedef enum logic [2:0] {IDLE, READ, CHECK, WB, CLEAR, DONE} state_t;
    state_t state;
    logic lastWay, lastSet;
    assign lastWay = bus.FlushWay[NUMWAYS-1];
    assign lastSet = bus.FlushAdr == SETLEN'(NUMLINES - 1);
    // Walk FSM; all outputs are registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            bus.FlushAdr   <= '0;
            bus.FlushWay   <= NUMWAYS'(1);
            bus.SelFlush   <= 1'b0;
            bus.WbReq      <= 1'b0;
            bus.ClearDirty <= 1'b0;
            bus.FlushBusy  <= 1'b0;
            bus.FlushDone  <= 1'b0;
        end else begin
            bus.WbReq      <= 1'b0;
            bus.ClearDirty <= 1'b0;
            bus.FlushDone  <= 1'b0;
            case (state)
                IDLE: if (bus.FlushReq) begin
                    state         <= READ;
                    bus.FlushAdr  <= '0;
                    bus.FlushWay  <= NUMWAYS'(1);
                    bus.SelFlush  <= 1'b1;
                    bus.FlushBusy <= 1'b1;
                end
                READ: state <= CHECK;
                CHECK, CLEAR: begin
                    if (state == CHECK && bus.LineDirty) begin
                        state     <= WB;
                        bus.WbReq <= 1'b1;
                    end else if (!lastWay) begin
                        bus.FlushWay <= bus.FlushWay << 1;
                        state        <= READ;
                    end else if (!lastSet) begin
                        bus.FlushWay <= NUMWAYS'(1);
                        bus.FlushAdr <= bus.FlushAdr + 1'b1;
                        state        <= READ;
                    end else begin
                        bus.FlushWay  <= NUMWAYS'(1);
                        bus.FlushAdr  <= '0;
                        bus.FlushDone <= 1'b1;
                        state         <= DONE;
                    end
                end
                WB: if (bus.WbAck) begin
                    state          <= CLEAR;
                    bus.ClearDirty <= 1'b1;
                end else begin
                    bus.WbReq <= 1'b1;
                end
                DONE: begin
                    state         <= IDLE;
                    bus.SelFlush  <= 1'b0;
                    bus.FlushBusy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_flush_walker.sv
// tb_cache_flush_walker: directed and randomized flush walks against a per-cycle expected trace
module tb_cache_flush_walker;
    localparam int L = 4;
    localparam int W = 2;
    typedef struct {
        int adr;
        int way;
        bit wb;
        bit clr;
    } step_t;
    logic clk = 1'b0;
    logic reset;
    int   nChecks = 0;
    int   nFail = 0;
    bit   dirty[L][W];
    int   ackDelay[L][W];
    step_t sched[$];
    cache_flush_walker_if #(.NUMLINES(L), .NUMWAYS(W)) bus ();
    cache_flush_walker_if #(.NUMLINES(2), .NUMWAYS(1)) bus6 ();
    cache_flush_walker #(.NUMLINES(L), .NUMWAYS(W)) dut (.clk(clk), .reset(reset), .bus(bus.master));
    cache_flush_walker #(.NUMLINES(2), .NUMWAYS(1)) dut6 (.clk(clk), .reset(reset), .bus(bus6.master));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setMap(input bit d, input int dly);
        for (int s = 0; s < L; s++)
            for (int w = 0; w < W; w++) begin
                dirty[s][w]    = d;
                ackDelay[s][w] = dly;
            end
    endtask

    // Expected per-cycle trace: 2 cycles per line, plus ack-delay WB cycles and 1 CLEAR cycle if dirty
    task automatic buildSched();
        sched.delete();
        for (int s = 0; s < L; s++)
            for (int w = 0; w < W; w++) begin
                sched.push_back('{s, w, 1'b0, 1'b0});
                sched.push_back('{s, w, 1'b0, 1'b0});
                if (dirty[s][w]) begin
                    repeat (ackDelay[s][w]) sched.push_back('{s, w, 1'b1, 1'b0});
                    sched.push_back('{s, w, 1'b0, 1'b1});
                end
            end
    endtask

    task automatic runWalk(input bit noise, input int abortAt);
        step_t e;
        int n, sz, wbRun, adrI, wayI;
        buildSched();
        sz = sched.size();
        wbRun = 0;
        @(negedge clk) bus.FlushReq = 1'b1;
        @(negedge clk) bus.FlushReq = 1'b0;
        for (n = 1; n <= sz + 2; n++) begin
            if (n > 1) @(negedge clk);
            if (n <= sz) begin
                e = sched[n-1];
                check("adr", 32'(bus.FlushAdr), e.adr);
                check("way", 32'(bus.FlushWay), 32'(1) << e.way);
                check("wbReq", 32'(bus.WbReq), 32'(e.wb));
                check("clearDirty", 32'(bus.ClearDirty), 32'(e.clr));
                check("busy", 32'({bus.FlushBusy, bus.SelFlush}), 32'h3);
                check("doneEarly", 32'(bus.FlushDone), 0);
                if (n == abortAt) begin
                    reset = 1'b1;
                    bus.WbAck = 1'b0;
                    bus.LineDirty = 1'b0;
                    @(negedge clk);
                    check("rstAdr", 32'(bus.FlushAdr), 0);
                    check("rstWay", 32'(bus.FlushWay), 1);
                    check("rstWbReq", 32'(bus.WbReq), 0);
                    check("rstClear", 32'(bus.ClearDirty), 0);
                    check("rstBusy", 32'({bus.FlushBusy, bus.SelFlush, bus.FlushDone}), 0);
                    reset = 1'b0;
                    @(negedge clk);
                    check("rstIdle", 32'({bus.FlushBusy, bus.ClearDirty, bus.WbReq}), 0);
                    return;
                end
            end else if (n == sz + 1) begin
                check("done", 32'(bus.FlushDone), 1);
                check("doneBusy", 32'(bus.FlushBusy), 1);
            end else begin
                check("idleBusy", 32'({bus.FlushBusy, bus.SelFlush, bus.FlushDone}), 0);
                check("idleAdr", 32'(bus.FlushAdr), 0);
                check("idleWay", 32'(bus.FlushWay), 1);
            end
            adrI = int'(bus.FlushAdr);
            wayI = 0;
            for (int w = 0; w < W; w++) if (bus.FlushWay[w]) wayI = w;
            bus.LineDirty = dirty[adrI][wayI];
            wbRun = bus.WbReq ? wbRun + 1 : 0;
            bus.WbAck = bus.WbReq ? (wbRun == ackDelay[adrI][wayI]) : (noise && $urandom_range(1, 0) == 1);
            bus.FlushReq = noise && n < sz && $urandom_range(1, 0) == 1;
        end
        bus.FlushReq = 1'b0;
        bus.WbAck = 1'b0;
        bus.LineDirty = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.FlushReq = 1'b0;
        bus.LineDirty = 1'b0;
        bus.WbAck = 1'b0;
        bus6.FlushReq = 1'b0;
        bus6.LineDirty = 1'b0;
        bus6.WbAck = 1'b0;
        repeat (2) @(negedge clk);
        check("resetAdr", 32'(bus.FlushAdr), 0);
        check("resetWay", 32'(bus.FlushWay), 1);
        check("resetOuts", 32'({bus.SelFlush, bus.WbReq, bus.ClearDirty, bus.FlushBusy, bus.FlushDone}), 0);
        check("reset6Way", 32'(bus6.FlushWay), 1);
        reset = 1'b0;
        // all clean walk
        setMap(1'b0, 1);
        runWalk(1'b0, 0);
        // single dirty line at (2, way 1), ack on the third WbReq cycle
        dirty[2][1] = 1'b1;
        ackDelay[2][1] = 3;
        runWalk(1'b0, 0);
        // every line dirty, ack in the first WbReq cycle
        setMap(1'b1, 1);
        runWalk(1'b0, 0);
        // reset lands during the writeback of (1, way 0), then a clean restart
        setMap(1'b0, 1);
        dirty[1][0] = 1'b1;
        ackDelay[1][0] = 100;
        runWalk(1'b0, 7);
        setMap(1'b0, 1);
        runWalk(1'b0, 0);
        // stray FlushReq and WbAck while walking a clean cache
        runWalk(1'b1, 0);
        // random dirty maps and ack delays with stray inputs
        repeat (4) begin
            for (int s = 0; s < L; s++)
                for (int w = 0; w < W; w++) begin
                    dirty[s][w] = $urandom_range(1, 0) == 1;
                    ackDelay[s][w] = $urandom_range(4, 1);
                end
            runWalk(1'b1, 0);
        end
        // single-way, two-set walker with FlushReq held: READ,CHECK x2, DONE, IDLE repeating
        @(negedge clk) bus6.FlushReq = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            check("t6Way", 32'(bus6.FlushWay), 1);
            check("t6Done", 32'(bus6.FlushDone), 32'((n % 6) == 5));
            check("t6Busy", 32'(bus6.FlushBusy), 32'((n % 6) != 0));
            check("t6Adr", 32'(bus6.FlushAdr), ((n - 1) % 6 < 4) ? ((n - 1) % 6) / 2 : 0);
            check("t6WbReq", 32'(bus6.WbReq), 0);
        end
        bus6.FlushReq = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
